mem_port_arb: RTL and testbench
===============================

Name: mem_port_arb

Overview:
- Single-port memory arbiter shared by three requesters:
  - instruction fetch (ifu),
  - load/store (lsu),
  - debug/JTAG access (dbg).
- Sits between the core front-end/LSU and the one memory bus.
- Grants one transaction at a time, holds ownership until the response returns, and routes the response back to the owner.
- Provides a starvation guard for fetch and a response timeout.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_LSU_STREAK, 4, consecutive lsu grants allowed while ifu is waiting; range 1..15
- TIMEOUT, 255, cycles in WAIT before a synthetic error response; range 1..255

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ifu_req_val  in  1  fetch request valid
- ifu_req_rdy  out  1  fetch request accepted
- ifu_addr  in  AW  fetch address
- ifu_rsp_val  out  1  fetch response, one-cycle pulse
- ifu_rsp_data  out  DW  fetch response data
- ifu_rsp_err  out  1  fetch response error
- lsu_req_val / lsu_req_rdy / lsu_addr  in/out/in  1/1/AW  data request
- lsu_wen  in  1  write enable
- lsu_wdata  in  DW  write data
- lsu_wstrb  in  DW/8  byte strobes
- lsu_rsp_val / lsu_rsp_data / lsu_rsp_err  out  1/DW/1  data response
- dbg_req_val / dbg_req_rdy / dbg_addr / dbg_wen / dbg_wdata / dbg_wstrb  same shapes as lsu  debug request
- dbg_rsp_val / dbg_rsp_data / dbg_rsp_err  out  1/DW/1  debug response
- mem_req_val  out  1  bus request valid
- mem_req_rdy  in  1  bus accepts request
- mem_addr  out  AW  bus address
- mem_wen  out  1  bus write enable
- mem_wdata  out  DW  bus write data
- mem_wstrb  out  DW/8  bus byte strobes
- mem_rsp_val  in  1  bus response valid
- mem_rsp_data  in  DW  bus response data
- mem_rsp_err  in  1  bus response error
- owner  out  2  current owner: 0 none, 1 ifu, 2 lsu, 3 dbg

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high.
- Reset values:
  - state=IDLE, owner=0, streak=0, timer=0.
  - All *_rsp_val=0 and all *_req_rdy=0.
  - mem_req_val=0, mem_wen=0, mem_wstrb=0.
- IDLE state, winner selection (combinational from current req_val):
  1. dbg wins whenever dbg_req_val=1.
  2. Otherwise, if ifu_req_val=1 and streak==MAX_LSU_STREAK, ifu wins.
  3. Otherwise lsu wins, then ifu.
- IDLE state, bus drive:
  - mem_req_val=1 when any req_val=1.
  - mem_addr/wen/wdata/wstrb are muxed from the winner. For an ifu winner, wen=0 and wstrb=0.
  - Only the winner's req_rdy mirrors mem_req_rdy; the others are 0.
- IDLE state, on handshake (mem_req_val & mem_req_rdy):
  - owner <= winner, state <= WAIT, timer <= 0.
  - Streak update:
    - lsu granted while ifu_req_val=1 -> streak+1, saturating at MAX_LSU_STREAK.
    - ifu granted -> streak <= 0.
    - dbg granted, or lsu granted with ifu idle -> streak unchanged.
- WAIT state:
  - mem_req_val=0 and every req_rdy=0; new requests are held off.
  - timer increments each cycle.
  - On mem_rsp_val=1:
    - Drive owner's rsp_val=1 with rsp_data=mem_rsp_data and rsp_err=mem_rsp_err, in the same cycle (combinational pass-through).
    - state <= IDLE, owner <= 0.
  - If timer==TIMEOUT-1 and mem_rsp_val=0:
    - Next cycle, state RESP_TO drives owner's rsp_val=1, rsp_data=0, rsp_err=1.
    - Then state <= IDLE, owner <= 0.
- Response latency and throughput:
  - A response is never accepted in the handshake cycle; the earliest is 1 cycle after the handshake.
  - A new request is accepted no earlier than the cycle after the response (max 1 transaction per 2 cycles).
- Boundary conditions:
  - mem_rsp_val in IDLE or RESP_TO (stray or late response): ignored, no rsp_val pulses.
  - Requester drops req_val before handshake: allowed. Winner is re-evaluated every IDLE cycle, so the grant is not sticky before handshake.
  - Simultaneous dbg+lsu+ifu with streak at max: dbg still wins; streak is unchanged, so ifu wins next.
  - Reset mid-WAIT: return to IDLE immediately; the outstanding response is dropped with no rsp_val.
  - Non-owner rsp_val, rsp_data and rsp_err are always 0.

Test Plan:
- Single fetch: ifu_req_val=1, addr=0x100, mem_req_rdy=1; response 2 cycles later with data 0x00000013 -> one handshake, owner=1, ifu_rsp_val pulses once with 0x00000013, lsu/dbg rsp_val stay 0.
- Priority: dbg, lsu and ifu request in the same cycle -> dbg granted first, then lsu, then ifu; each grant is issued only after the previous response.
- Starvation guard: MAX_LSU_STREAK=4, lsu and ifu held valid continuously -> grant order lsu×4, ifu, lsu×4, ifu; streak returns to 0 after each ifu grant.
- Timeout: TIMEOUT=8, lsu write accepted, mem_rsp_val never asserted -> lsu_rsp_val=1 with err=1 and data=0 exactly 9 cycles after the handshake. A later stray mem_rsp_val is ignored.
- Reset mid-WAIT: dbg read accepted, rst=1 for one cycle before the response -> owner=0, no dbg_rsp_val. A mem_rsp_val arriving after reset produces no pulse, and a fresh ifu request is accepted normally.
- Backpressure: mem_req_rdy=0 for 5 cycles with lsu valid -> lsu_req_rdy=0 throughout, bus signals stable, and the handshake occurs in the cycle mem_req_rdy rises.

Source files
------------

// File: rtl/mem_port_arb.sv
// Single-port memory arbiter for fetch, load/store and debug requesters.
// One transaction in flight at a time; the response is routed back to the owner.
module mem_port_arb #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int MAX_LSU_STREAK = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_req_val,
  output logic            ifu_req_rdy,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_rsp_val,
  output logic [DW-1:0]   ifu_rsp_data,
  output logic            ifu_rsp_err,
  input  logic            lsu_req_val,
  output logic            lsu_req_rdy,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wstrb,
  output logic            lsu_rsp_val,
  output logic [DW-1:0]   lsu_rsp_data,
  output logic            lsu_rsp_err,
  input  logic            dbg_req_val,
  output logic            dbg_req_rdy,
  input  logic [AW-1:0]   dbg_addr,
  input  logic            dbg_wen,
  input  logic [DW-1:0]   dbg_wdata,
  input  logic [DW/8-1:0] dbg_wstrb,
  output logic            dbg_rsp_val,
  output logic [DW-1:0]   dbg_rsp_data,
  output logic            dbg_rsp_err,
  output logic            mem_req_val,
  input  logic            mem_req_rdy,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_rsp_val,
  input  logic [DW-1:0]   mem_rsp_data,
  input  logic            mem_rsp_err,
  output logic [1:0]      owner
);

  localparam int SW = DW / 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESP_TO = 2'd2
  } state_t;

  localparam logic [1:0] OWN_NONE   = 2'd0;
  localparam logic [1:0] OWN_IFU    = 2'd1;
  localparam logic [1:0] OWN_LSU    = 2'd2;
  localparam logic [1:0] OWN_DBG    = 2'd3;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_LSU_STREAK);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t        state_r, state_next_s;
  logic [1:0]    owner_r, owner_next_s, winner_s;
  logic [3:0]    streak_r, streak_next_s;
  logic [7:0]    timer_r, timer_next_s;
  logic          any_req_s, idle_s, hs_s, rsp_hit_s, rsp_err_s;
  logic [DW-1:0] rsp_data_s;

  assign any_req_s = ifu_req_val | lsu_req_val | dbg_req_val;
  assign idle_s    = (state_r == ST_IDLE) && !rst;
  assign hs_s      = idle_s && any_req_s && mem_req_rdy;
  assign owner     = owner_r;

  // Winner selection: debug first, fetch once the lsu streak is exhausted, then lsu, then fetch.
  always_comb begin
    winner_s = OWN_NONE;
    if (dbg_req_val) begin
      winner_s = OWN_DBG;
    end else if (ifu_req_val && (streak_r == STREAK_MAX)) begin
      winner_s = OWN_IFU;
    end else if (lsu_req_val) begin
      winner_s = OWN_LSU;
    end else if (ifu_req_val) begin
      winner_s = OWN_IFU;
    end else begin
      winner_s = OWN_NONE;
    end
  end

  // Bus request mux and per-requester ready, only while idle.
  always_comb begin
    mem_req_val = 1'b0;
    mem_addr    = {AW{1'b0}};
    mem_wen     = 1'b0;
    mem_wdata   = {DW{1'b0}};
    mem_wstrb   = {SW{1'b0}};
    ifu_req_rdy = 1'b0;
    lsu_req_rdy = 1'b0;
    dbg_req_rdy = 1'b0;
    if (idle_s) begin
      mem_req_val = any_req_s;
      case (winner_s)
        OWN_IFU: begin
          mem_addr    = ifu_addr;
          ifu_req_rdy = mem_req_rdy;
        end
        OWN_LSU: begin
          mem_addr    = lsu_addr;
          mem_wen     = lsu_wen;
          mem_wdata   = lsu_wdata;
          mem_wstrb   = lsu_wstrb;
          lsu_req_rdy = mem_req_rdy;
        end
        OWN_DBG: begin
          mem_addr    = dbg_addr;
          mem_wen     = dbg_wen;
          mem_wdata   = dbg_wdata;
          mem_wstrb   = dbg_wstrb;
          dbg_req_rdy = mem_req_rdy;
        end
        default: begin
          mem_addr = {AW{1'b0}};
        end
      endcase
    end else begin
      mem_req_val = 1'b0;
    end
  end

  // Response routing: bus response passes straight through in WAIT, synthetic error in RESP_TO.
  always_comb begin
    rsp_hit_s    = 1'b0;
    rsp_data_s   = {DW{1'b0}};
    rsp_err_s    = 1'b0;
    ifu_rsp_val  = 1'b0;
    ifu_rsp_data = {DW{1'b0}};
    ifu_rsp_err  = 1'b0;
    lsu_rsp_val  = 1'b0;
    lsu_rsp_data = {DW{1'b0}};
    lsu_rsp_err  = 1'b0;
    dbg_rsp_val  = 1'b0;
    dbg_rsp_data = {DW{1'b0}};
    dbg_rsp_err  = 1'b0;
    if (rst) begin
      rsp_hit_s = 1'b0;
    end else if (state_r == ST_WAIT) begin
      rsp_hit_s  = mem_rsp_val;
      rsp_data_s = mem_rsp_data;
      rsp_err_s  = mem_rsp_err;
    end else if (state_r == ST_RESP_TO) begin
      rsp_hit_s  = 1'b1;
      rsp_data_s = {DW{1'b0}};
      rsp_err_s  = 1'b1;
    end else begin
      rsp_hit_s = 1'b0;
    end
    if (rsp_hit_s) begin
      case (owner_r)
        OWN_IFU: begin
          ifu_rsp_val  = 1'b1;
          ifu_rsp_data = rsp_data_s;
          ifu_rsp_err  = rsp_err_s;
        end
        OWN_LSU: begin
          lsu_rsp_val  = 1'b1;
          lsu_rsp_data = rsp_data_s;
          lsu_rsp_err  = rsp_err_s;
        end
        OWN_DBG: begin
          dbg_rsp_val  = 1'b1;
          dbg_rsp_data = rsp_data_s;
          dbg_rsp_err  = rsp_err_s;
        end
        default: begin
          ifu_rsp_val = 1'b0;
        end
      endcase
    end else begin
      ifu_rsp_val = 1'b0;
    end
  end

  // Next-state, ownership, fetch-starvation streak and response timer.
  always_comb begin
    state_next_s  = state_r;
    owner_next_s  = owner_r;
    streak_next_s = streak_r;
    timer_next_s  = timer_r;
    case (state_r)
      ST_IDLE: begin
        if (hs_s) begin
          state_next_s = ST_WAIT;
          owner_next_s = winner_s;
          timer_next_s = 8'd0;
          if ((winner_s == OWN_LSU) && ifu_req_val) begin
            streak_next_s = (streak_r == STREAK_MAX) ? streak_r : streak_r + 4'd1;
          end else if (winner_s == OWN_IFU) begin
            streak_next_s = 4'd0;
          end else begin
            streak_next_s = streak_r;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        timer_next_s = timer_r + 8'd1;
        if (mem_rsp_val) begin
          state_next_s = ST_IDLE;
          owner_next_s = OWN_NONE;
        end else if (timer_r == TIMER_LAST) begin
          state_next_s = ST_RESP_TO;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_RESP_TO: begin
        state_next_s = ST_IDLE;
        owner_next_s = OWN_NONE;
      end
      default: begin
        state_next_s = ST_IDLE;
        owner_next_s = OWN_NONE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      owner_r  <= OWN_NONE;
      streak_r <= 4'd0;
      timer_r  <= 8'd0;
    end else begin
      state_r  <= state_next_s;
      owner_r  <= owner_next_s;
      streak_r <= streak_next_s;
      timer_r  <= timer_next_s;
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: directed scenarios plus a randomized run
// against a transaction-level model of grant priority, fetch streak and response routing.
module tb_mem_port_arb;
  localparam int AW = 32, DW = 32, SW = 4, MAXS = 4, TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic ifu_req_val, ifu_req_rdy, ifu_rsp_val, ifu_rsp_err;
  logic [AW-1:0] ifu_addr;
  logic [DW-1:0] ifu_rsp_data;
  logic lsu_req_val, lsu_req_rdy, lsu_wen, lsu_rsp_val, lsu_rsp_err;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rsp_data;
  logic [SW-1:0] lsu_wstrb;
  logic dbg_req_val, dbg_req_rdy, dbg_wen, dbg_rsp_val, dbg_rsp_err;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rsp_data;
  logic [SW-1:0] dbg_wstrb;
  logic mem_req_val, mem_req_rdy, mem_wen, mem_rsp_val, mem_rsp_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rsp_data;
  logic [SW-1:0] mem_wstrb;
  logic [1:0] owner;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arb #(.AW(AW), .DW(DW), .MAX_LSU_STREAK(MAXS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_val(ifu_req_val), .ifu_req_rdy(ifu_req_rdy), .ifu_addr(ifu_addr),
    .ifu_rsp_val(ifu_rsp_val), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_val(lsu_req_val), .lsu_req_rdy(lsu_req_rdy), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_rsp_val(lsu_rsp_val), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
    .dbg_req_val(dbg_req_val), .dbg_req_rdy(dbg_req_rdy), .dbg_addr(dbg_addr),
    .dbg_wen(dbg_wen), .dbg_wdata(dbg_wdata), .dbg_wstrb(dbg_wstrb),
    .dbg_rsp_val(dbg_rsp_val), .dbg_rsp_data(dbg_rsp_data), .dbg_rsp_err(dbg_rsp_err),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_val(mem_rsp_val), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .owner(owner)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_req_val = 1'b0; ifu_addr = '0;
    lsu_req_val = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wstrb = '0;
    dbg_req_val = 1'b0; dbg_addr = '0; dbg_wen = 1'b0; dbg_wdata = '0; dbg_wstrb = '0;
    mem_req_rdy = 1'b0; mem_rsp_val = 1'b0; mem_rsp_data = '0; mem_rsp_err = 1'b0;
  endtask

  // Grant priority straight from the arbitration rules.
  function automatic int model_winner(bit i, bit l, bit d, int streak);
    if (d) return 3;
    if (i && streak == MAXS) return 1;
    if (l) return 2;
    if (i) return 1;
    return 0;
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    ifu_req_val = 1'b1; lsu_req_val = 1'b1; dbg_req_val = 1'b1; dbg_wen = 1'b1;
    dbg_wstrb = 4'hf; mem_req_rdy = 1'b1; mem_rsp_val = 1'b1;
    tick(); tick();
    n_tests++;
    if ({ifu_req_rdy, lsu_req_rdy, dbg_req_rdy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_rdy got=%b want=000", {ifu_req_rdy, lsu_req_rdy, dbg_req_rdy});
    end
    n_tests++;
    if ({mem_req_val, mem_wen, mem_wstrb} !== 6'b0) begin
      n_fail++; $display("FAIL reset_bus got=%b want=0", {mem_req_val, mem_wen, mem_wstrb});
    end
    n_tests++;
    if ({ifu_rsp_val, lsu_rsp_val, dbg_rsp_val} !== 3'b000 || owner !== 2'd0) begin
      n_fail++; $display("FAIL reset_rsp_owner rsp=%b owner=%0d want 000/0",
                         {ifu_rsp_val, lsu_rsp_val, dbg_rsp_val}, owner);
    end
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_single_fetch();
    int pulses = 0;
    bit other = 1'b0;
    ifu_req_val = 1'b1; ifu_addr = 32'h100; mem_req_rdy = 1'b1;
    lsu_wen = 1'b1; dbg_wstrb = 4'hf;
    #1;
    n_tests++;
    if ({ifu_req_rdy, mem_req_val, mem_wen, mem_wstrb} !== 7'b1100000 || mem_addr !== 32'h100) begin
      n_fail++; $display("FAIL fetch_req rdy=%b val=%b wen=%b strb=%h addr=%h want 1/1/0/0/100",
                         ifu_req_rdy, mem_req_val, mem_wen, mem_wstrb, mem_addr);
    end
    tick();
    ifu_req_val = 1'b0;
    #1;
    n_tests++;
    if (owner !== 2'd1 || mem_req_val !== 1'b0) begin
      n_fail++; $display("FAIL fetch_owner owner=%0d mem_req_val=%b want 1/0", owner, mem_req_val);
    end
    for (int k = 1; k <= 4; k++) begin
      mem_rsp_val = (k == 2); mem_rsp_data = 32'h13;
      #1;
      if (ifu_rsp_val) begin
        pulses++;
        n_tests++;
        if (ifu_rsp_data !== 32'h13 || ifu_rsp_err !== 1'b0) begin
          n_fail++; $display("FAIL fetch_data got=%h err=%b want 00000013/0", ifu_rsp_data, ifu_rsp_err);
        end
      end
      if (lsu_rsp_val || dbg_rsp_val) other = 1'b1;
      tick();
    end
    n_tests++;
    if (pulses != 1 || other || owner !== 2'd0) begin
      n_fail++; $display("FAIL fetch_pulse pulses=%0d other=%b owner=%0d want 1/0/0", pulses, other, owner);
    end
    idle_inputs();
  endtask

  task automatic test_priority();
    int order[$];
    bit pi = 1'b1, pl = 1'b1, pd = 1'b1, busy_rdy = 1'b0;
    int cyc = 0;
    mem_req_rdy = 1'b1;
    while ((pi || pl || pd || owner != 2'd0) && cyc < 40) begin
      ifu_req_val = pi; lsu_req_val = pl; dbg_req_val = pd;
      mem_rsp_val = (owner != 2'd0); mem_rsp_data = $urandom;
      #1;
      if (owner != 2'd0 && (ifu_req_rdy || lsu_req_rdy || dbg_req_rdy)) busy_rdy = 1'b1;
      if (dbg_req_rdy) begin order.push_back(3); pd = 1'b0; end
      if (lsu_req_rdy) begin order.push_back(2); pl = 1'b0; end
      if (ifu_req_rdy) begin order.push_back(1); pi = 1'b0; end
      tick();
      cyc++;
    end
    n_tests++;
    if (order.size() != 3 || busy_rdy) begin
      n_fail++; $display("FAIL prio_count grants=%0d rdy_while_busy=%b want 3/0", order.size(), busy_rdy);
    end else begin
      n_tests++;
      if (order[0] != 3 || order[1] != 2 || order[2] != 1) begin
        n_fail++; $display("FAIL prio_order got=%0d,%0d,%0d want 3,2,1", order[0], order[1], order[2]);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_starvation();
    int grants[$];
    int streak = 0;
    int cyc = 0;
    int exp_g;
    rst = 1'b1; tick(); rst = 1'b0;
    lsu_req_val = 1'b1; ifu_req_val = 1'b1; mem_req_rdy = 1'b1;
    while (grants.size() < 10 && cyc < 80) begin
      mem_rsp_val = (owner != 2'd0);
      #1;
      if (lsu_req_rdy) grants.push_back(2);
      if (ifu_req_rdy) grants.push_back(1);
      tick();
      cyc++;
    end
    n_tests++;
    if (grants.size() != 10) begin
      n_fail++; $display("FAIL starve_count grants=%0d want 10", grants.size());
    end
    foreach (grants[i]) begin
      if (streak == MAXS) begin exp_g = 1; streak = 0; end
      else begin exp_g = 2; streak++; end
      n_tests++;
      if (grants[i] != exp_g) begin
        n_fail++; $display("FAIL starve_grant[%0d] got=%0d want %0d", i, grants[i], exp_g);
      end
    end
    idle_inputs();
    mem_rsp_val = 1'b1;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    bit exp_p;
    lsu_req_val = 1'b1; lsu_wen = 1'b1; lsu_addr = $urandom; lsu_wdata = $urandom;
    lsu_wstrb = 4'hf; mem_req_rdy = 1'b1;
    #1;
    n_tests++;
    if (lsu_req_rdy !== 1'b1 || mem_wen !== 1'b1) begin
      n_fail++; $display("FAIL to_accept rdy=%b wen=%b want 1/1", lsu_req_rdy, mem_wen);
    end
    tick();
    idle_inputs();
    for (int k = 1; k <= 10; k++) begin
      mem_rsp_val = (k == 9); mem_rsp_data = 32'hdeadbeef; mem_rsp_err = 1'b0;
      #1;
      exp_p = (k == 9);
      n_tests++;
      if (lsu_rsp_val !== exp_p || ifu_rsp_val !== 1'b0 || dbg_rsp_val !== 1'b0) begin
        n_fail++; $display("FAIL to_pulse k=%0d lsu=%b ifu=%b dbg=%b want %b/0/0",
                           k, lsu_rsp_val, ifu_rsp_val, dbg_rsp_val, exp_p);
      end
      if (k == 9) begin
        n_tests++;
        if (lsu_rsp_data !== 32'h0 || lsu_rsp_err !== 1'b1) begin
          n_fail++; $display("FAIL to_payload data=%h err=%b want 0/1", lsu_rsp_data, lsu_rsp_err);
        end
      end
      n_tests++;
      if (owner !== ((k == 10) ? 2'd0 : 2'd2)) begin
        n_fail++; $display("FAIL to_owner k=%0d got=%0d", k, owner);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      mem_rsp_val = 1'b1; mem_rsp_data = $urandom;
      #1;
      n_tests++;
      if ({ifu_rsp_val, lsu_rsp_val, dbg_rsp_val} !== 3'b000) begin
        n_fail++; $display("FAIL to_stray got=%b want 000", {ifu_rsp_val, lsu_rsp_val, dbg_rsp_val});
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_wait();
    logic [DW-1:0] d;
    dbg_req_val = 1'b1; dbg_addr = $urandom; mem_req_rdy = 1'b1;
    #1;
    n_tests++;
    if (dbg_req_rdy !== 1'b1) begin
      n_fail++; $display("FAIL rmw_accept got=%b want 1", dbg_req_rdy);
    end
    tick();
    dbg_req_val = 1'b0; rst = 1'b1;
    #1;
    n_tests++;
    if (dbg_rsp_val !== 1'b0 || owner !== 2'd3) begin
      n_fail++; $display("FAIL rmw_in_reset rsp=%b owner=%0d want 0/3", dbg_rsp_val, owner);
    end
    tick();
    rst = 1'b0;
    mem_rsp_val = 1'b1; mem_rsp_data = $urandom;
    #1;
    n_tests++;
    if (owner !== 2'd0 || {ifu_rsp_val, lsu_rsp_val, dbg_rsp_val} !== 3'b000) begin
      n_fail++; $display("FAIL rmw_after owner=%0d rsp=%b want 0/000", owner,
                         {ifu_rsp_val, lsu_rsp_val, dbg_rsp_val});
    end
    tick();
    mem_rsp_val = 1'b0;
    ifu_req_val = 1'b1; ifu_addr = 32'h200;
    #1;
    n_tests++;
    if (ifu_req_rdy !== 1'b1 || mem_addr !== 32'h200) begin
      n_fail++; $display("FAIL rmw_fetch rdy=%b addr=%h want 1/200", ifu_req_rdy, mem_addr);
    end
    tick();
    ifu_req_val = 1'b0;
    d = $urandom;
    mem_rsp_val = 1'b1; mem_rsp_data = d;
    #1;
    n_tests++;
    if (ifu_rsp_val !== 1'b1 || ifu_rsp_data !== d) begin
      n_fail++; $display("FAIL rmw_fetch_rsp val=%b data=%h want 1/%h", ifu_rsp_val, ifu_rsp_data, d);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    a = $urandom; w = $urandom;
    lsu_req_val = 1'b1; lsu_addr = a; lsu_wen = 1'b1; lsu_wdata = w; lsu_wstrb = 4'b0110;
    mem_req_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (lsu_req_rdy !== 1'b0 || owner !== 2'd0 ||
          {mem_req_val, mem_addr, mem_wen, mem_wdata, mem_wstrb} !== {1'b1, a, 1'b1, w, 4'b0110}) begin
        n_fail++; $display("FAIL bp_hold[%0d] rdy=%b val=%b addr=%h wdata=%h strb=%b want 0/1/%h/%h/0110",
                           i, lsu_req_rdy, mem_req_val, mem_addr, mem_wdata, mem_wstrb, a, w);
      end
      tick();
    end
    mem_req_rdy = 1'b1;
    #1;
    n_tests++;
    if (lsu_req_rdy !== 1'b1) begin
      n_fail++; $display("FAIL bp_rise rdy=%b want 1", lsu_req_rdy);
    end
    tick();
    lsu_req_val = 1'b0;
    #1;
    n_tests++;
    if (owner !== 2'd2) begin
      n_fail++; $display("FAIL bp_owner got=%0d want 2", owner);
    end
    mem_rsp_val = 1'b1;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    bit m_busy = 1'b0;
    int m_owner = 0, m_streak = 0, m_lat = 0, m_cnt = 0, win;
    bit any;
    logic [DW+1:0] e_i, e_l, e_d;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (m_busy) m_cnt++;
      ifu_req_val = ($urandom_range(0, 9) < 6);
      lsu_req_val = ($urandom_range(0, 9) < 7);
      dbg_req_val = ($urandom_range(0, 9) < 1);
      ifu_addr = $urandom; lsu_addr = $urandom; dbg_addr = $urandom;
      lsu_wen = $urandom; dbg_wen = $urandom;
      lsu_wdata = $urandom; dbg_wdata = $urandom;
      lsu_wstrb = 4'($urandom); dbg_wstrb = 4'($urandom);
      mem_req_rdy = ($urandom_range(0, 3) != 0);
      mem_rsp_data = $urandom; mem_rsp_err = $urandom;
      if (m_busy) mem_rsp_val = (m_cnt == m_lat);
      else mem_rsp_val = ($urandom_range(0, 4) == 0);
      #1;
      any = ifu_req_val | lsu_req_val | dbg_req_val;
      win = m_busy ? 0 : model_winner(ifu_req_val, lsu_req_val, dbg_req_val, m_streak);
      n_tests++;
      if (owner !== 2'(m_owner)) begin
        n_fail++; $display("FAIL rnd_owner c=%0d got=%0d want %0d", c, owner, m_owner);
      end
      n_tests++;
      if ({mem_req_val, ifu_req_rdy, lsu_req_rdy, dbg_req_rdy} !==
          {!m_busy && any, (win == 1) && mem_req_rdy, (win == 2) && mem_req_rdy, (win == 3) && mem_req_rdy}) begin
        n_fail++; $display("FAIL rnd_req c=%0d got val=%b rdy=%b%b%b win=%0d", c, mem_req_val,
                           ifu_req_rdy, lsu_req_rdy, dbg_req_rdy, win);
      end
      if (win != 0) begin
        n_tests++;
        if ((win == 1 && {mem_addr, mem_wen, mem_wstrb} !== {ifu_addr, 1'b0, 4'h0}) ||
            (win == 2 && {mem_addr, mem_wen, mem_wdata, mem_wstrb} !== {lsu_addr, lsu_wen, lsu_wdata, lsu_wstrb}) ||
            (win == 3 && {mem_addr, mem_wen, mem_wdata, mem_wstrb} !== {dbg_addr, dbg_wen, dbg_wdata, dbg_wstrb})) begin
          n_fail++; $display("FAIL rnd_bus c=%0d win=%0d addr=%h wen=%b wdata=%h strb=%h", c, win,
                             mem_addr, mem_wen, mem_wdata, mem_wstrb);
        end
      end
      e_i = '0; e_l = '0; e_d = '0;
      if (m_busy && mem_rsp_val) begin
        if (m_owner == 1) e_i = {1'b1, mem_rsp_data, mem_rsp_err};
        if (m_owner == 2) e_l = {1'b1, mem_rsp_data, mem_rsp_err};
        if (m_owner == 3) e_d = {1'b1, mem_rsp_data, mem_rsp_err};
      end
      n_tests++;
      if ({ifu_rsp_val, ifu_rsp_data, ifu_rsp_err, lsu_rsp_val, lsu_rsp_data, lsu_rsp_err,
           dbg_rsp_val, dbg_rsp_data, dbg_rsp_err} !== {e_i, e_l, e_d}) begin
        n_fail++; $display("FAIL rnd_rsp c=%0d got=%h/%h/%h want %h/%h/%h", c,
                           {ifu_rsp_val, ifu_rsp_data, ifu_rsp_err}, {lsu_rsp_val, lsu_rsp_data, lsu_rsp_err},
                           {dbg_rsp_val, dbg_rsp_data, dbg_rsp_err}, e_i, e_l, e_d);
      end
      if (!m_busy && any && mem_req_rdy) begin
        if (win == 2 && ifu_req_val && m_streak < MAXS) m_streak++;
        else if (win == 1) m_streak = 0;
        m_busy = 1'b1; m_owner = win; m_cnt = 0; m_lat = $urandom_range(1, 4);
      end else if (m_busy && mem_rsp_val) begin
        m_busy = 1'b0; m_owner = 0;
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    test_reset();
    test_single_fetch();
    test_priority();
    test_starvation();
    test_timeout();
    test_reset_mid_wait();
    test_backpressure();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
